samplerz_sched: RTL and testbench
=================================

SAMPLERZ_SCHED -- requirements
Module: samplerz_sched

Interface
REQ-001 Parameter ADDR_W, default 10, memory word-address width for sampler operands.
REQ-002 Parameter LEN_W, default 10, width of the batch-length and sample-count fields.
REQ-003 Parameter WDOG_CYCLES, default 1024, maximum cycles allowed between op_start and op_done.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 batch_start  input  1  one-cycle request to run a batch.
REQ-007 batch_len  input  LEN_W  number of samples in the batch, sampled with batch_start.
REQ-008 base_addr  input  ADDR_W  first operand address, sampled with batch_start.
REQ-009 abort  input  1  cancels the batch in progress.
REQ-010 busy  output  1  high while a batch is active.
REQ-011 batch_done  output  1  one-cycle pulse at batch completion.
REQ-012 op_start  output  1  one-cycle start pulse to the sampler task interface.
REQ-013 op_addr  output  ADDR_W  operand address for the current sample, valid while busy.
REQ-014 op_done  input  1  sampler completion pulse.
REQ-015 sample_cnt  output  LEN_W  samples completed in the current or last batch.
REQ-016 timeout_err  output  1  sticky watchdog error flag.

Function
REQ-017 FSM states are IDLE, ISSUE, WAIT and FIN.
- IDLE + batch_start with batch_len>0 -> ISSUE.
- IDLE + batch_start with batch_len==0 -> FIN.
- ISSUE -> WAIT after one cycle, with op_start=1 during that ISSUE cycle.
- WAIT + op_done -> ISSUE if samples remain, else FIN.
- FIN -> IDLE after one cycle, with batch_done=1 during that FIN cycle.
REQ-018 batch_start asserted in cycle N produces op_start in cycle N+1; with batch_len==0 it produces batch_done in cycle N+1 and no op_start.
REQ-019 op_done in cycle M produces the next op_start, or batch_done on the last sample, in cycle M+1.
REQ-020 op_addr = base_addr + sample index, computed modulo 2^ADDR_W; wrap-around is legal and silent.
REQ-021 sample_cnt is cleared on an accepted batch_start, increments on each op_done received in WAIT, and holds its value after the batch ends.
REQ-022 busy is high in ISSUE, WAIT and FIN.
REQ-023 batch_start is ignored while busy.
REQ-024 op_done is ignored outside WAIT.
REQ-025 An op_done coincident with op_start (ISSUE state) is ignored.
REQ-026 abort in any non-IDLE state forces IDLE on the next cycle, with no batch_done and no further op_start; sample_cnt holds its value.
REQ-027 abort has priority over op_done in the same cycle.
REQ-028 abort in IDLE has no effect.
REQ-029 batch_start and abort asserted together in IDLE: batch_start wins and the batch starts.

Reset
REQ-030 rst_n low asynchronously forces IDLE and sets busy, batch_done, op_start, op_addr, sample_cnt and timeout_err to 0.
REQ-031 Reset asserted mid-batch discards the batch; no batch_done is issued after reset is released.

Configuration
REQ-032 With macro SAMPLERZ_SCHED_WDOG_EN defined, the watchdog is compiled in:
- A counter is cleared on entry to WAIT and increments each cycle in WAIT.
- If it reaches WDOG_CYCLES-1 without op_done, timeout_err is set, the FSM goes to IDLE without batch_done, and busy drops.
- timeout_err is cleared only by reset or an accepted batch_start.
REQ-033 Without SAMPLERZ_SCHED_WDOG_EN, no watchdog logic exists, WAIT waits indefinitely, and timeout_err is tied to 0.

Verification
REQ-034 batch_start with batch_len=3, base_addr=0x010, op_done returned 5 cycles after each op_start -> three op_start pulses with op_addr 0x010, 0x011, 0x012; batch_done one cycle after the third op_done; sample_cnt=3.
REQ-035 batch_len=0 -> batch_done in cycle N+1, no op_start, busy high for exactly one cycle.
REQ-036 base_addr=0x3FF, batch_len=2 -> op_addr 0x3FF then 0x000.
REQ-037 abort in the same cycle as the second op_done of a 4-sample batch -> IDLE next cycle, no batch_done, sample_cnt=1; a second batch_start while busy is ignored.
REQ-038 With SAMPLERZ_SCHED_WDOG_EN and WDOG_CYCLES=16, op_done withheld -> timeout_err=1 after 16 cycles in WAIT, busy=0; the next batch_start clears timeout_err.
REQ-039 rst_n pulsed low mid-WAIT -> all outputs 0 immediately; a late op_done after reset release has no effect.

Source files
------------

// File: rtl/samplerz_sched_if.sv
// Host/sampler handshake bundle for samplerz_sched: batch request, sampler
// task strobes and status. The scheduler takes the slave side.
interface samplerz_sched_if #(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 10
);
  logic              batch_start;
  logic [LEN_W-1:0]  batch_len;
  logic [ADDR_W-1:0] base_addr;
  logic              abort;
  logic              busy;
  logic              batch_done;
  logic              op_start;
  logic [ADDR_W-1:0] op_addr;
  logic              op_done;
  logic [LEN_W-1:0]  sample_cnt;
  logic              timeout_err;

  modport master (
    output batch_start, batch_len, base_addr, abort, op_done,
    input  busy, batch_done, op_start, op_addr, sample_cnt, timeout_err
  );

  modport slave (
    input  batch_start, batch_len, base_addr, abort, op_done,
    output busy, batch_done, op_start, op_addr, sample_cnt, timeout_err
  );
endinterface

// File: rtl/samplerz_sched.sv
// Batch scheduler: issues one sampler op per sample at base_addr+index.
// Optional WAIT-state watchdog compiled in with SAMPLERZ_SCHED_WDOG_EN.
module samplerz_sched #(
  parameter int ADDR_W      = 10,
  parameter int LEN_W       = 10,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  samplerz_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  cnt_nxt;
  logic              accept;
  logic              done_ok;

  if (WDOG_CYCLES < 2) begin : g_bad_wdog
    $error("WDOG_CYCLES must be at least 2");
  end

  assign accept  = (state == IDLE) && bus.batch_start;
  // abort outranks a coincident op_done, so the count never advances on it
  assign done_ok = (state == WAIT) && bus.op_done && !bus.abort;
  assign cnt_nxt = cnt_q + 1'b1;

`ifdef SAMPLERZ_SCHED_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
  logic [WD_W-1:0] wdog_q;
  logic            wdog_hit;
  logic            terr_q;

  assign wdog_hit = (state == WAIT) && (wdog_q == WD_W'(WDOG_CYCLES - 1));

  // counter restarts every ISSUE, so it is zero on the first WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      terr_q <= 1'b0;
    end else begin
      if (state == ISSUE)     wdog_q <= '0;
      else if (state == WAIT) wdog_q <= wdog_q + 1'b1;
      if (accept)                                      terr_q <= 1'b0;
      else if (wdog_hit && !bus.op_done && !bus.abort) terr_q <= 1'b1;
    end
  end

  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.batch_start) state_nxt = (bus.batch_len == '0) ? FIN : ISSUE;
      ISSUE: state_nxt = bus.abort ? IDLE : WAIT;
      WAIT: begin
        if (bus.abort)        state_nxt = IDLE;
        else if (bus.op_done) state_nxt = (cnt_nxt == len_q) ? FIN : ISSUE;
`ifdef SAMPLERZ_SCHED_WDOG_EN
        else if (wdog_hit)    state_nxt = IDLE;
`endif
      end
      FIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      base_q <= bus.base_addr;
      len_q  <= bus.batch_len;
      cnt_q  <= '0;
    end else if (done_ok) begin
      cnt_q  <= cnt_nxt;
    end
  end

  // completed-sample count doubles as the index of the sample being issued
  assign bus.op_addr    = base_q + ADDR_W'(cnt_q);
  assign bus.sample_cnt = cnt_q;
  assign bus.busy       = (state != IDLE);
  assign bus.op_start   = (state == ISSUE);
  assign bus.batch_done = (state == FIN);
endmodule

// File: tb/tb_samplerz_sched.sv
// Directed bench for samplerz_sched; hand-computed expectations, one check
// per step. Watchdog checks follow SAMPLERZ_SCHED_WDOG_EN.
module tb_samplerz_sched;
  logic clk;
  logic rst_n;
  int   applied;
  int   miscompares;

  samplerz_sched_if #(.ADDR_W(10), .LEN_W(10)) bus ();

  samplerz_sched #(.ADDR_W(10), .LEN_W(10), .WDOG_CYCLES(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    applied = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.batch_start = 1'b0;
    bus.batch_len   = '0;
    bus.base_addr   = '0;
    bus.abort       = 1'b0;
    bus.op_done     = 1'b0;
    tick(); tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_batch_done", bus.batch_done, 0);
    chk("rst_op_start", bus.op_start, 0);
    chk("rst_op_addr", bus.op_addr, 0);
    chk("rst_sample_cnt", bus.sample_cnt, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    rst_n = 1'b1;
    tick();

    // three samples from 0x010, op_done five cycles after each op_start
    bus.batch_start = 1'b1; bus.batch_len = 10'd3; bus.base_addr = 10'h010;
    tick();
    bus.batch_start = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk("b3_op_start", bus.op_start, 1);
      chk("b3_op_addr", bus.op_addr, 32'h010 + s);
      chk("b3_busy", bus.busy, 1);
      if (s == 0) bus.op_done = 1'b1;
      tick();
      bus.op_done = 1'b0;
      chk("b3_op_start_pulse", bus.op_start, 0);
      chk("b3_cnt_wait", bus.sample_cnt, s);
      repeat (4) tick();
      bus.op_done = 1'b1;
      tick();
      bus.op_done = 1'b0;
    end
    chk("b3_batch_done", bus.batch_done, 1);
    chk("b3_no_op_start", bus.op_start, 0);
    chk("b3_cnt", bus.sample_cnt, 3);
    tick();
    chk("b3_idle_busy", bus.busy, 0);
    chk("b3_done_pulse", bus.batch_done, 0);
    chk("b3_cnt_hold", bus.sample_cnt, 3);

    // zero-length batch
    bus.batch_start = 1'b1; bus.batch_len = 10'd0; bus.base_addr = 10'h055;
    tick();
    bus.batch_start = 1'b0;
    chk("z_batch_done", bus.batch_done, 1);
    chk("z_op_start", bus.op_start, 0);
    chk("z_busy", bus.busy, 1);
    chk("z_cnt", bus.sample_cnt, 0);
    tick();
    chk("z_busy_drop", bus.busy, 0);
    chk("z_done_pulse", bus.batch_done, 0);
    chk("z_op_start2", bus.op_start, 0);

    // address wrap-around
    bus.batch_start = 1'b1; bus.batch_len = 10'd2; bus.base_addr = 10'h3FF;
    tick();
    bus.batch_start = 1'b0;
    chk("w_addr0", bus.op_addr, 32'h3FF);
    tick();
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    chk("w_op_start1", bus.op_start, 1);
    chk("w_addr1", bus.op_addr, 32'h000);
    tick();
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    chk("w_batch_done", bus.batch_done, 1);
    chk("w_cnt", bus.sample_cnt, 2);
    tick();
    // op_done and abort in IDLE do nothing
    bus.op_done = 1'b1; bus.abort = 1'b1;
    tick();
    bus.op_done = 1'b0; bus.abort = 1'b0;
    chk("idle_ignore_cnt", bus.sample_cnt, 2);
    chk("idle_ignore_busy", bus.busy, 0);

    // abort with the second op_done; restart attempt while busy ignored
    bus.batch_start = 1'b1; bus.batch_len = 10'd4; bus.base_addr = 10'h020;
    tick();
    bus.batch_start = 1'b0;
    tick();
    bus.op_done = 1'b1;
    bus.batch_start = 1'b1; bus.batch_len = 10'd7; bus.base_addr = 10'h100;
    tick();
    bus.op_done = 1'b0; bus.batch_start = 1'b0;
    chk("ab_op_addr", bus.op_addr, 32'h021);
    chk("ab_cnt1", bus.sample_cnt, 1);
    tick();
    bus.op_done = 1'b1; bus.abort = 1'b1;
    tick();
    bus.op_done = 1'b0; bus.abort = 1'b0;
    chk("ab_busy", bus.busy, 0);
    chk("ab_batch_done", bus.batch_done, 0);
    chk("ab_op_start", bus.op_start, 0);
    chk("ab_cnt", bus.sample_cnt, 1);
    tick();
    chk("ab_batch_done2", bus.batch_done, 0);
    chk("ab_op_start2", bus.op_start, 0);

    // batch_start beats abort in IDLE; then abort in ISSUE
    bus.batch_start = 1'b1; bus.abort = 1'b1; bus.batch_len = 10'd1; bus.base_addr = 10'h100;
    tick();
    bus.batch_start = 1'b0;
    chk("sa_op_start", bus.op_start, 1);
    chk("sa_op_addr", bus.op_addr, 32'h100);
    tick();
    bus.abort = 1'b0;
    chk("sa_busy", bus.busy, 0);
    chk("sa_op_start2", bus.op_start, 0);

`ifdef SAMPLERZ_SCHED_WDOG_EN
    // watchdog: 16 cycles in WAIT without op_done
    bus.batch_start = 1'b1; bus.batch_len = 10'd1; bus.base_addr = 10'h000;
    tick();
    bus.batch_start = 1'b0;
    tick();
    repeat (15) tick();
    chk("wd_busy_before", bus.busy, 1);
    chk("wd_err_before", bus.timeout_err, 0);
    tick();
    chk("wd_busy", bus.busy, 0);
    chk("wd_err", bus.timeout_err, 1);
    chk("wd_batch_done", bus.batch_done, 0);
    tick();
    chk("wd_err_sticky", bus.timeout_err, 1);
    bus.batch_start = 1'b1; bus.batch_len = 10'd0;
    tick();
    bus.batch_start = 1'b0;
    chk("wd_err_clear", bus.timeout_err, 0);
    chk("wd_done_after", bus.batch_done, 1);
    tick();
`else
    // no watchdog: WAIT holds indefinitely
    bus.batch_start = 1'b1; bus.batch_len = 10'd1; bus.base_addr = 10'h000;
    tick();
    bus.batch_start = 1'b0;
    repeat (40) tick();
    chk("nowd_busy", bus.busy, 1);
    chk("nowd_err", bus.timeout_err, 0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("nowd_abort", bus.busy, 0);
`endif

    // asynchronous reset mid-WAIT, then a late op_done
    bus.batch_start = 1'b1; bus.batch_len = 10'd2; bus.base_addr = 10'h040;
    tick();
    bus.batch_start = 1'b0;
    tick();
    tick();
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    chk("ar_cnt_pre", bus.sample_cnt, 1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_op_start", bus.op_start, 0);
    chk("ar_op_addr", bus.op_addr, 0);
    chk("ar_cnt", bus.sample_cnt, 0);
    chk("ar_batch_done", bus.batch_done, 0);
    chk("ar_err", bus.timeout_err, 0);
    tick();
    rst_n = 1'b1;
    bus.op_done = 1'b1;
    tick();
    bus.op_done = 1'b0;
    chk("ar_late_busy", bus.busy, 0);
    chk("ar_late_done", bus.batch_done, 0);
    chk("ar_late_cnt", bus.sample_cnt, 0);
    tick();
    chk("ar_late_done2", bus.batch_done, 0);
    chk("ar_late_start", bus.op_start, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
